// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID capture of the imem word.
// Latency: 1 cycle from pc to IF/ID (instruction memory is read combinationally).
// Backpressure: stall holds pc and IF/ID; a redirect overrides stall and flushes IF/ID.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   stall                       hold pc and IF/ID this edge
//   redirect_valid/kind         resolved control transfer (00 branch, 01 J/JAL, 10 JR, 11 ignored)
//   redirect_pc4/imm/index/reg  operands for the target computation
//   imem_addr, imem_instr       word address out, instruction back (same cycle)
//   pc                          current program counter
//   if_instr/if_pc/if_pc4       IF/ID register contents
//   if_valid                    IF/ID holds a real instruction
//   addr_fault                  sticky fetch-address fault, cleared only by rst
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] IMEM_BASE = 32'h0040_0000,
  parameter int          ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_kind,
  input  logic [31:0]       redirect_pc4,
  input  logic [15:0]       redirect_imm,
  input  logic [25:0]       redirect_index,
  input  logic [31:0]       redirect_reg,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic [31:0]       pc,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc4,
  output logic              if_valid,
  output logic              addr_fault
);

  // Window size in bytes, held in 33 bits so a 30-bit word address still fits.
  localparam logic [32:0] WINDOW_BYTES = 33'd4 << ADDR_W;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JUMP   = 2'b01;
  localparam logic [1:0] KIND_JR     = 2'b10;

  logic [31:0] offset;
  logic        fetch_ok;
  logic [31:0] pc_plus4;
  logic        redirect_take;
  logic [31:0] target;
  logic [31:0] branch_disp;

  // Byte offset into the instruction window; addresses below the base wrap
  // to huge values and so fail the window check below.
  assign offset    = pc - IMEM_BASE;
  assign imem_addr = offset[ADDR_W+1:2];
  assign fetch_ok  = (pc[1:0] == 2'b00) && ({1'b0, offset} < WINDOW_BYTES);
  assign pc_plus4  = pc + 32'd4;

  // Reserved kind 11 behaves exactly as if no redirect was presented.
  assign redirect_take = redirect_valid && (redirect_kind != 2'b11);

  assign branch_disp = {{14{redirect_imm[15]}}, redirect_imm, 2'b00};

  always_comb begin
    target = redirect_reg;
    case (redirect_kind)
      KIND_BRANCH: target = redirect_pc4 + branch_disp;
      KIND_JUMP:   target = {redirect_pc4[31:28], redirect_index, 2'b00};
      KIND_JR:     target = redirect_reg;
      default:     target = redirect_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      if_instr   <= 32'd0;
      if_pc      <= 32'd0;
      if_pc4     <= 32'd0;
      if_valid   <= 1'b0;
      addr_fault <= 1'b0;
    end else if (addr_fault) begin
      // Frozen until reset: nothing further is fetched or accepted.
      if_valid <= 1'b0;
    end else if (redirect_take) begin
      // No delay slot: whatever was fetched behind the transfer is squashed.
      pc       <= target;
      if_instr <= 32'd0;
      if_pc    <= 32'd0;
      if_pc4   <= 32'd0;
      if_valid <= 1'b0;
    end else if (stall) begin
      // Hold everything; stall never creates a bubble on its own.
    end else if (fetch_ok) begin
      if_instr <= imem_instr;
      if_pc    <= pc;
      if_pc4   <= pc_plus4;
      if_valid <= 1'b1;
      pc       <= pc_plus4;
    end else begin
      // Bad fetch: raise the sticky fault, keep pc pointing at the offender.
      addr_fault <= 1'b1;
      if_valid   <= 1'b0;
      if_instr   <= 32'd0;
    end
  end

endmodule
